// File: rtl/signed_accumulator.sv
// Signed accumulator with valid/ready handshake on both sides and a sticky overflow flag.
// Define SIGNED_ACC_SAT_EN to saturate on overflow instead of wrapping.
module signed_accumulator #(
    parameter int SIZE     = 8,
    parameter int ACC_SIZE = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_data,
    input  logic                in_sub,
    input  logic                in_clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_SIZE-1:0] out_data,
    output logic                overflow
);

    logic                valid_q, valid_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic [ACC_SIZE-1:0] base;
    logic [ACC_SIZE-1:0] operand_ext;
    logic [ACC_SIZE-1:0] operand_eff;
    logic [ACC_SIZE-1:0] sum;
    logic                sum_ovf;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign base        = in_clear ? '0 : acc_q;
    assign operand_ext = {{(ACC_SIZE-SIZE){in_data[SIZE-1]}}, in_data};
    // Negating in the wider accumulator width keeps the most-negative operand exact.
    assign operand_eff = in_sub ? (~operand_ext + 1'b1) : operand_ext;
    assign sum         = base + operand_eff;
    assign sum_ovf     = (base[ACC_SIZE-1] == operand_eff[ACC_SIZE-1])
                      && (sum[ACC_SIZE-1] != base[ACC_SIZE-1]);

    always_comb begin
        valid_d = valid_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (accept) begin
            valid_d = 1'b1;
`ifdef SIGNED_ACC_SAT_EN
            if (sum_ovf)
                acc_d = base[ACC_SIZE-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                                         : {1'b0, {(ACC_SIZE-1){1'b1}}};
            else
                acc_d = sum;
`else
            acc_d = sum;
`endif
            ovf_d = in_clear ? sum_ovf : (ovf_q | sum_ovf);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Bench for signed_accumulator: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an integer-arithmetic model.
module tb_signed_accumulator;

    localparam int SIZE = 8;
    localparam int ACC  = 12;
    localparam int MAXV = 2047;
    localparam int MINV = -2048;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [SIZE-1:0] in_data;
    logic                   in_sub;
    logic                   in_clear;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACC-1:0]  out_data;
    logic                   overflow;

    int n_checks = 0;
    int n_fail   = 0;

    signed_accumulator #(.SIZE(SIZE), .ACC_SIZE(ACC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sub   (in_sub),
        .in_clear (in_clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: exact integer result, then wrap or saturate into ACC bits.
    typedef struct packed { int acc; bit ov; } res_t;

    function automatic res_t model_step(int base, int d, bit sub);
        res_t r;
        int   full;
        full = sub ? base - d : base + d;
        r.ov = (full > MAXV) || (full < MINV);
`ifdef SIGNED_ACC_SAT_EN
        r.acc = (full > MAXV) ? MAXV : (full < MINV) ? MINV : full;
`else
        r.acc = ((full - MINV) % 4096 + 4096) % 4096 + MINV;
`endif
        return r;
    endfunction

    int m_acc;
    bit m_valid;
    bit m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc   <= 0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            res_t r;
            r = model_step(in_clear ? 0 : m_acc, int'(in_data), in_sub);
            m_acc   <= r.acc;
            m_valid <= 1'b1;
            m_ovf   <= in_clear ? r.ov : (m_ovf | r.ov);
            $display("txn: %s %0d clear=%0d -> expect %0d ovf=%0d",
                     in_sub ? "sub" : "add", int'(in_data), in_clear, r.acc,
                     in_clear ? r.ov : (m_ovf | r.ov));
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Cycle-by-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        chk("cyc_out_valid", int'(out_valid), int'(m_valid));
        chk("cyc_out_data",  int'(out_data),  m_acc);
        chk("cyc_overflow",  int'(overflow),  int'(m_ovf));
        chk("cyc_in_ready",  int'(in_ready),  int'(!m_valid || out_ready));
    end

    // Drive one cycle of inputs just after an edge, return just after the next edge.
    task automatic apply(input bit v, input bit sub, input bit clr, input int d, input bit ordy);
        in_valid  = v;
        in_sub    = sub;
        in_clear  = clr;
        in_data   = SIZE'(d);
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_clear = 1'b0;
        in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data",  int'(out_data),  0);
        chk("reset_overflow",  int'(overflow),  0);
        chk("reset_in_ready",  int'(in_ready),  1);
        rst_n = 1'b1;

        // Basic add sequence
        apply(1, 0, 0, 5, 1);
        chk("add5_data", int'(out_data), 5);
        chk("add5_valid", int'(out_valid), 1);
        apply(1, 0, 0, -3, 1);
        chk("addm3_data", int'(out_data), 2);
        chk("addm3_ovf", int'(overflow), 0);
        apply(0, 1, 1, 99, 1);
        chk("idle_valid", int'(out_valid), 0);
        chk("idle_data", int'(out_data), 2);

        // Stall holds the result, release accepts on that edge
        apply(1, 0, 0, 10, 1);
        chk("pre_stall_data", int'(out_data), 12);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 7, 0);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_data", int'(out_data), 12);
            chk("stall_valid", int'(out_valid), 1);
        end
        apply(1, 0, 0, 7, 1);
        chk("unstall_data", int'(out_data), 19);

        // Subtracting the most-negative operand is exact
        apply(1, 1, 1, -128, 1);
        chk("subm128_data", int'(out_data), 128);
        chk("subm128_ovf", int'(overflow), 0);

        // Positive overflow after 17 x 127
        apply(1, 0, 1, 127, 1);
        for (int i = 0; i < 16; i++) apply(1, 0, 0, 127, 1);
`ifdef SIGNED_ACC_SAT_EN
        chk("ovf17_data", int'(out_data), 2047);
`else
        chk("ovf17_data", int'(out_data), -1937);
`endif
        chk("ovf17_flag", int'(overflow), 1);
        apply(1, 0, 0, 1, 1);
`ifdef SIGNED_ACC_SAT_EN
        chk("ovf_sticky_data", int'(out_data), 2047);
`else
        chk("ovf_sticky_data", int'(out_data), -1936);
`endif
        chk("ovf_sticky_flag", int'(overflow), 1);
        apply(0, 0, 1, 0, 1);
        chk("ovf_idle_flag", int'(overflow), 1);

        // Clear drops overflow
        apply(1, 0, 1, 3, 1);
        chk("clear_data", int'(out_data), 3);
        chk("clear_ovf", int'(overflow), 0);

        // Async reset in the middle of a stall
        apply(1, 0, 0, 50, 1);
        chk("pre_rst_data", int'(out_data), 53);
        apply(1, 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_data",  int'(out_data),  0);
        chk("async_rst_ovf",   int'(overflow),  0);
        chk("async_rst_ready", int'(in_ready),  1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_no_accept", int'(out_valid), 0);
        rst_n = 1'b1;
        apply(1, 0, 0, 9, 1);
        chk("post_rst_data", int'(out_data), 9);

        // Randomized traffic, covered by the per-cycle compare
        for (int i = 0; i < 2000; i++) begin
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 3) != 0);
        end
        apply(0, 0, 0, 0, 1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_accumulator.md
SIGNED_ACCUMULATOR -- requirements
Module: signed_accumulator

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the operand width in bits (two's complement).
REQ-002 The block SHALL have parameter ACC_SIZE, default 12, giving the accumulator width in bits; ACC_SIZE >= SIZE+1 is required.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand presented.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 in_data  input  SIZE  signed operand.
REQ-009 in_sub  input  1  1 = subtract operand, 0 = add operand.
REQ-010 in_clear  input  1  1 = treat the accumulator as 0 before applying this operand.
REQ-011 out_valid  output  1  out_data holds a result not yet consumed.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_data  output  ACC_SIZE  signed accumulator value.
REQ-014 overflow  output  1  sticky signed-overflow flag.

Function
REQ-015 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-016 An operand SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 On accept, the base value SHALL be 0 if in_clear is 1, else out_data.
REQ-018 On accept, the next value SHALL be base + sext(in_data) when in_sub is 0, and base - sext(in_data) when in_sub is 1, computed in ACC_SIZE bits.
REQ-019 On accept, the next value SHALL be registered into out_data with 1-cycle latency, and out_valid SHALL be set.
REQ-020 out_valid SHALL clear on a rising edge where out_valid && out_ready && no accept occurs.
REQ-021 Simultaneous consume and accept SHALL keep out_valid at 1 with the new value (full throughput, one operand per cycle).
REQ-022 While out_valid && !out_ready (stall), out_data, out_valid and overflow SHALL hold, and in_ready SHALL be 0.
REQ-023 Signed overflow SHALL be detected when the effective operand and the base have equal signs and the result sign differs; for subtraction the effective operand is -sext(in_data).
REQ-024 An accept with overflow SHALL set overflow to 1.
REQ-025 overflow SHALL remain 1 until reset or an accepted in_clear operation.
REQ-026 An accepted in_clear operation SHALL load overflow with that operation's own overflow result, which is always 0 given REQ-002.
REQ-027 Subtracting the most-negative operand (e.g. -128 with SIZE=8) SHALL be exact, because ACC_SIZE > SIZE.
REQ-028 When in_valid is 0, accumulator state SHALL be unchanged regardless of in_sub, in_clear and in_data.

Reset
REQ-029 Asserting rst_n low SHALL immediately force out_valid=0, out_data=0 and overflow=0, independent of clk, including in the middle of a stall.
REQ-030 During reset, in_ready SHALL read 1, per REQ-015; no operand SHALL be accepted while rst_n is 0.
REQ-031 After rst_n deasserts, the first accept SHALL use base 0.

Configuration
REQ-032 Macro SIGNED_ACC_SAT_EN SHALL control saturation.
REQ-033 When SIGNED_ACC_SAT_EN is defined, an overflowing accept SHALL load out_data with 2^(ACC_SIZE-1)-1 on positive overflow or -2^(ACC_SIZE-1) on negative overflow, and SHALL still set overflow.
REQ-034 When SIGNED_ACC_SAT_EN is undefined, out_data SHALL take the wrapped two's-complement result, and overflow SHALL still set.

Verification (SIZE=8, ACC_SIZE=12, out_ready=1 unless stated)
REQ-035 Reset, then add 5, then add -3 -> out_data 5 then 2, out_valid 1 each cycle, overflow 0.
REQ-036 Stall: out_ready=0 with out_valid=1 and in_valid=1 -> in_ready 0, out_data held for 3 cycles; raise out_ready -> next operand accepted on that edge.
REQ-037 in_clear=1, in_sub=1, in_data=-128 -> out_data 128, overflow 0.
REQ-038 Add 127 seventeen times from 0 -> without macro out_data -1937 with overflow 1, staying 1 after a following add 1; with SIGNED_ACC_SAT_EN out_data 2047 with overflow 1.
REQ-039 Overflow set, then accept in_clear=1 add 3 -> out_data 3, overflow 0.
REQ-040 Drop rst_n mid-stall between clock edges -> out_valid 0, out_data 0, overflow 0 before the next clk edge.
